// File: rtl/banked_mem_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : banked_mem_unit_if
//  Description : Request/response bundle for banked_mem_unit. A request is
//                taken when req_valid & req_ready at a rising edge. A
//                response is taken when resp_valid & resp_ready at a rising
//                edge.
//  Ports       : req_valid/req_ready, req_store, req_size, req_signed,
//                req_addr, req_wdata (master -> slave request channel);
//                resp_valid/resp_ready, resp_rdata, resp_err (slave ->
//                master response channel)
//  Revision    : 1.0 - initial release
// ============================================================================
interface banked_mem_unit_if #(
    parameter int LANES = 4,
    parameter int AW    = 32
);
    localparam int DW = 8 * LANES;

    logic          req_valid;
    logic          req_ready;
    logic          req_store;
    logic [1:0]    req_size;
    logic          req_signed;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] resp_rdata;
    logic          resp_err;

    modport master (
        output req_valid, req_store, req_size, req_signed, req_addr, req_wdata,
        output resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_store, req_size, req_signed, req_addr, req_wdata,
        input  resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface
`default_nettype wire

// File: rtl/banked_mem_unit.sv
`default_nettype none
// ============================================================================
//  Module      : banked_mem_unit
//  Description : MEM-stage data memory built from LANES byte-wide synchronous
//                banks. Byte address A lives in bank A mod LANES, row
//                A / LANES. The lanes are rotated so that any access of up to
//                LANES bytes, aligned or not, needs one bank cycle. A stage of
//                in-flight information plus a registered response stage give
//                a two-edge load latency with full-rate throughput and
//                back-pressure.
//  Ports       : CLOCK_50 - clock, rising edge
//                resetn   - synchronous active-low reset
//                bus      - banked_mem_unit_if.slave request/response channel
//  Options     : MISALIGN_TRAP_EN - when defined, an access whose address is
//                not a multiple of its size is rejected with resp_err.
//  Revision    : 1.0 - initial release
// ============================================================================
module banked_mem_unit #(
    parameter int LANES   = 4,
    parameter int BANK_AW = 16,
    parameter int AW      = 32
) (
    input  logic              CLOCK_50,
    input  logic              resetn,
    banked_mem_unit_if.slave  bus
);
    localparam int L    = $clog2(LANES);
    localparam int DW   = 8 * LANES;
    localparam int ROWS = 2 ** BANK_AW;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic               w_ready;
    logic               w_accept;
    logic               w_move;
    logic               w_err;
    logic               w_size_err;
    logic               w_range_err;
    logic               w_misalign;
    logic [3:0]         w_req_nbytes;
    logic [L-1:0]       w_off;
    logic [BANK_AW-1:0] w_row_base;
    logic [AW-1:0]      w_hi;

    // Stage 1: access in flight through the banks
    logic               inflight_q;
    logic [1:0]         inf_size_q;
    logic               inf_signed_q;
    logic               inf_store_q;
    logic               inf_err_q;
    logic [L-1:0]       inf_rot_q;

    // Stage 2: response register
    logic               resp_valid_q;
    logic [DW-1:0]      resp_rdata_q;
    logic               resp_err_q;
    logic [DW-1:0]      rdata_d;

    logic [DW-1:0]      w_bank_dout;
    logic [DW-1:0]      w_unrot;
    logic [3:0]         w_nbytes_q;
    logic               w_sign;

    assign w_req_nbytes = 4'd1 << bus.req_size;
    assign w_off        = bus.req_addr[L-1:0];
    assign w_row_base   = bus.req_addr[BANK_AW+L-1:L];
    // Anything at or above the total capacity is out of range; a span that
    // merely crosses the top row wraps its row index and is legal.
    assign w_hi         = bus.req_addr >> (BANK_AW + L);
    assign w_range_err  = |w_hi;
    assign w_size_err   = int'(bus.req_size) > L;

`ifdef MISALIGN_TRAP_EN
    assign w_misalign   = (bus.req_addr[2:0] & (w_req_nbytes[2:0] - 3'd1)) != 3'd0;
`else
    assign w_misalign   = 1'b0;
`endif

    assign w_err    = w_size_err | w_range_err | w_misalign;

    // Only a stalled response with the in-flight slot also occupied blocks
    // new requests; otherwise the in-flight access advances this edge.
    assign w_ready  = ~(inflight_q & resp_valid_q & ~bus.resp_ready);
    assign w_accept = bus.req_valid & w_ready & resetn;
    assign w_move   = ~resp_valid_q | bus.resp_ready;

    assign bus.req_ready  = w_ready;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;

    // ------------------------------------------------------------------
    // Banks. Bank b holds byte k = (b - A) mod LANES of the access; banks
    // below the start offset belong to the next row.
    // ------------------------------------------------------------------
    for (genvar b = 0; b < LANES; b++) begin : g_bank
        logic [L-1:0]       w_k;
        logic [BANK_AW-1:0] w_row;
        logic               w_we;
        logic [7:0]         mem_q [ROWS];
        logic [7:0]         dout_q;

        assign w_k   = L'(b) - w_off;
        assign w_row = w_row_base + {{(BANK_AW-1){1'b0}}, (L'(b) < w_off)};
        assign w_we  = w_accept & bus.req_store & ~w_err
                     & (int'(w_k) < int'(w_req_nbytes));

        // Banks are enabled only on acceptance, so dout holds while stalled.
        always_ff @(posedge CLOCK_50) begin
            if (w_accept) begin
                if (w_we) begin
                    mem_q[w_row] <= bus.req_wdata[8*w_k +: 8];
                end
                dout_q <= mem_q[w_row];
            end
        end

        assign w_bank_dout[8*b +: 8] = dout_q;
    end

    // Undo the lane rotation: byte k of the result came from bank k + A.
    for (genvar k = 0; k < LANES; k++) begin : g_unrot
        logic [L-1:0] w_src;
        assign w_src = L'(k) + inf_rot_q;
        assign w_unrot[8*k +: 8] = w_bank_dout[8*w_src +: 8];
    end

    // ------------------------------------------------------------------
    // Load formatting: mask to the access size, then extend.
    // ------------------------------------------------------------------
    assign w_nbytes_q = 4'd1 << inf_size_q;

    always_comb begin
        w_sign  = 1'b0;
        rdata_d = '0;
        for (int k = 0; k < LANES; k++) begin
            if (k == int'(w_nbytes_q) - 1) begin
                w_sign = inf_signed_q & w_unrot[8*k+7];
            end
        end
        for (int k = 0; k < LANES; k++) begin
            if (k < int'(w_nbytes_q)) begin
                rdata_d[8*k +: 8] = w_unrot[8*k +: 8];
            end else begin
                rdata_d[8*k +: 8] = {8{w_sign}};
            end
        end
        if (inf_store_q | inf_err_q) begin
            rdata_d = '0;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: in-flight access
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            inflight_q   <= 1'b0;
            inf_size_q   <= 2'd0;
            inf_signed_q <= 1'b0;
            inf_store_q  <= 1'b0;
            inf_err_q    <= 1'b0;
            inf_rot_q    <= '0;
        end else if (w_accept) begin
            inflight_q   <= 1'b1;
            inf_size_q   <= bus.req_size;
            inf_signed_q <= bus.req_signed;
            inf_store_q  <= bus.req_store;
            inf_err_q    <= w_err;
            inf_rot_q    <= w_off;
        end else if (w_move) begin
            inflight_q   <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: response register, held while stalled
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else if (w_move) begin
            resp_valid_q <= inflight_q;
            if (inflight_q) begin
                resp_rdata_q <= rdata_d;
                resp_err_q   <= inf_err_q;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_banked_mem_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_banked_mem_unit
//  Description : Self-checking bench for banked_mem_unit (LANES=4,
//                BANK_AW=16). A byte-array memory model and a response queue
//                predict every output each cycle; selected vectors also carry
//                hand-computed literal results. Honours MISALIGN_TRAP_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_banked_mem_unit;
    localparam int LANES   = 4;
    localparam int BANK_AW = 16;
    localparam int AW      = 32;
    localparam int CAP     = LANES << BANK_AW;
`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    banked_mem_unit_if #(.LANES(LANES), .AW(AW)) bus ();

    banked_mem_unit #(.LANES(LANES), .BANK_AW(BANK_AW), .AW(AW)) dut (
        .CLOCK_50 (clk),
        .resetn   (resetn),
        .bus      (bus)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          acc;
        logic        lit_en;
        logic [31:0] lit_data;
        logic        lit_err;
    } resp_t;

    resp_t       q[$];
    logic [7:0]  mem_m [int];
    int          nvec = 0;
    int          nmis = 0;
    int          cyc  = 0;
    logic        lit_en = 1'b0;
    logic [31:0] lit_data = '0;
    logic        lit_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: byte-addressed memory with capacity CAP, wrap at the top.
    function automatic void model(input logic st, input logic [1:0] sz, input logic sg,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  output logic [31:0] d, output logic e);
        int nb = 1 << sz;
        logic [63:0] v = '0;
        e = (nb > LANES) || (a >= CAP);
        if (TRAP && (a % nb != 0)) e = 1'b1;
        d = '0;
        if (e) return;
        if (st) begin
            for (int k = 0; k < nb; k++) mem_m[int'((a + k) % CAP)] = wd[8*k +: 8];
            return;
        end
        for (int k = 0; k < nb; k++) v[8*k +: 8] = mem_m[int'((a + k) % CAP)];
        if (sg && v[8*nb-1]) for (int k = nb; k < LANES; k++) v[8*k +: 8] = 8'hFF;
        d = v[31:0];
    endfunction

    // Compare process: samples one time unit before each rising edge.
    resp_t m_e;
    logic [31:0] m_d;
    logic        m_err;
    logic        m_expv;
    always @(negedge clk) begin
        #4;
        cyc++;
        if (!resetn) begin
            q.delete();
        end else begin
            m_expv = (q.size() > 0) && (q[0].acc + 2 <= cyc);
            check("resp_valid", 32'(bus.resp_valid), 32'(m_expv));
            check("req_ready", 32'(bus.req_ready), 32'(!(q.size() == 2 && !bus.resp_ready)));
            if (m_expv && bus.resp_valid) begin
                check("resp_rdata", bus.resp_rdata, q[0].data);
                check("resp_err", 32'(bus.resp_err), 32'(q[0].err));
                if (q[0].lit_en) begin
                    check("lit_rdata", bus.resp_rdata, q[0].lit_data);
                    check("lit_err", 32'(bus.resp_err), 32'(q[0].lit_err));
                end
                if (bus.resp_ready) void'(q.pop_front());
            end
            if (bus.req_valid && bus.req_ready) begin
                model(bus.req_store, bus.req_size, bus.req_signed, bus.req_addr,
                      bus.req_wdata, m_d, m_err);
                m_e.data     = m_d;
                m_e.err      = m_err;
                m_e.acc      = cyc;
                m_e.lit_en   = lit_en;
                m_e.lit_data = lit_data;
                m_e.lit_err  = lit_err;
                q.push_back(m_e);
            end
        end
    end

    // Present a request at the current falling edge and hold it until taken.
    task automatic issue(input logic st, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic len, input logic [31:0] ld, input logic le);
        int  t = 0;
        bit  acc = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_store  = st;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        lit_en   = len;
        lit_data = ld;
        lit_err  = le;
        while (!acc) begin
            #4;
            acc = bus.req_ready;
            @(negedge clk);
            t++;
            if (!acc && t > 20) begin
                nvec++;
                nmis++;
                $display("FAIL issue_timeout: got no acceptance required acceptance at addr %h", a);
                break;
            end
        end
        bus.req_valid = 1'b0;
        lit_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1);
    end

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_store  = 1'b0;
        bus.req_size   = 2'd0;
        bus.req_signed = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.resp_ready = 1'b1;
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        #4;
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_resp_rdata", bus.resp_rdata, 32'd0);
        check("rst_resp_err", 32'(bus.resp_err), 32'd0);
        @(negedge clk);

        // st, size, signed, addr, wdata, literal-enable, literal data, literal err
        issue(1, 2, 0, 32'h100,   32'h11223344, 1, 32'h0, 1'b0);
        issue(0, 2, 0, 32'h100,   32'h0,        1, 32'h11223344, 1'b0);
        issue(1, 2, 0, 32'h200,   32'h0,        0, 32'h0, 1'b0);
        issue(1, 2, 0, 32'h204,   32'h0,        0, 32'h0, 1'b0);
        issue(1, 2, 0, 32'h203,   32'hAABBCCDD, 1, 32'h0, TRAP);
        issue(0, 0, 1, 32'h203,   32'h0,        1, TRAP ? 32'h0 : 32'hFFFFFFDD, 1'b0);
        issue(0, 1, 0, 32'h205,   32'h0,        1, TRAP ? 32'h0 : 32'h0000AABB, TRAP);
        issue(1, 2, 0, 32'h10,    32'h0,        0, 32'h0, 1'b0);
        issue(1, 0, 0, 32'h10,    32'h80,       1, 32'h0, 1'b0);
        issue(0, 2, 0, 32'h10,    32'h0,        1, 32'h00000080, 1'b0);
        issue(0, 0, 1, 32'h10,    32'h0,        1, 32'hFFFFFF80, 1'b0);
        issue(0, 3, 0, 32'h100,   32'h0,        1, 32'h0, 1'b1);
        issue(1, 2, 0, 32'h0,     32'h0,        0, 32'h0, 1'b0);
        issue(1, 2, 0, 32'h40000, 32'hDEADBEEF, 1, 32'h0, 1'b1);
        issue(0, 2, 0, 32'h0,     32'h0,        1, 32'h0, 1'b0);
        issue(1, 2, 0, 32'h3FFFE, 32'h55667788, 1, 32'h0, TRAP);
        issue(0, 2, 0, 32'h0,     32'h0,        1, TRAP ? 32'h0 : 32'h00005566, 1'b0);
        repeat (3) @(negedge clk);

        // Back-pressure: two loads fill the pipe, the third must wait.
        bus.resp_ready = 1'b0;
        issue(0, 2, 0, 32'h100, 32'h0, 1, 32'h11223344, 1'b0);
        issue(0, 2, 0, 32'h10,  32'h0, 1, 32'h00000080, 1'b0);
        bus.req_valid  = 1'b1;
        bus.req_store  = 1'b0;
        bus.req_size   = 2'd1;
        bus.req_signed = 1'b1;
        bus.req_addr   = 32'h100;
        repeat (3) begin
            #4;
            check("bp_ready_low", 32'(bus.req_ready), 32'd0);
            @(negedge clk);
        end
        bus.resp_ready = 1'b1;
        issue(0, 1, 1, 32'h100, 32'h0, 1, 32'h00003344, 1'b0);
        repeat (4) @(negedge clk);

        // Reset with a response stalled and a load in flight.
        issue(1, 2, 0, 32'h300, 32'h0BADF00D, 0, 32'h0, 1'b0);
        bus.resp_ready = 1'b0;
        issue(0, 2, 0, 32'h100, 32'h0, 0, 32'h0, 1'b0);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        #4;
        check("midrst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("midrst_req_ready", 32'(bus.req_ready), 32'd1);
        check("midrst_resp_rdata", bus.resp_rdata, 32'd0);
        check("midrst_resp_err", 32'(bus.resp_err), 32'd0);
        @(negedge clk);
        bus.resp_ready = 1'b1;
        issue(0, 2, 0, 32'h300, 32'h0, 1, 32'h0BADF00D, 1'b0);
        repeat (4) @(negedge clk);
        check("drain", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
`default_nettype wire
